// File: rtl/uart_command_decoder.sv
// UART 8N1 receiver that assembles 6-byte packets (command, address, 32-bit data)
// and presents them on registered outputs with a one-cycle done pulse.
`timescale 1ns/1ps
module uart_command_decoder #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_in,
  output logic [7:0]  o_command,
  output logic [7:0]  o_address,
  output logic [31:0] o_data,
  output logic        o_done
);

  localparam int CNT_W     = $clog2(CLKS_PER_BIT + 1);
  localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W      = $clog2(TO_CYCLES + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
  typedef enum logic [2:0] {CMD, ADDR, D0, D1, D2, D3} stage_t;

  // Input synchronizer: line is idle high, so flops reset to 1
  logic sync_p0, sync_p1;
  logic rx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= uart_in;
      sync_p1 <= sync_p0;
    end
  end

  assign rx = sync_p1;

  // Byte receiver
  rx_state_t        rx_state, rx_state_nxt;
  logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       shift, shift_nxt;
  logic             byte_vld, frame_err;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      rx_state <= rx_state_nxt;
      clk_cnt  <= clk_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      shift    <= shift_nxt;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    clk_cnt_nxt  = clk_cnt;
    bit_idx_nxt  = bit_idx;
    shift_nxt    = shift;
    byte_vld     = 1'b0;
    frame_err    = 1'b0;
    case (rx_state)
      IDLE: begin
        clk_cnt_nxt = '0;
        bit_idx_nxt = '0;
        if (!rx) rx_state_nxt = START;
      end
      START: begin
        if (clk_cnt == HALF_LAST) begin
          clk_cnt_nxt  = '0;
          rx_state_nxt = rx ? IDLE : DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      DATA: begin
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx, shift[7:1]};
          bit_idx_nxt = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_nxt = STOP;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      STOP: begin
        // Returning to IDLE right after the stop sample lets a back-to-back start edge be seen next cycle
        if (clk_cnt == BIT_LAST) begin
          clk_cnt_nxt  = '0;
          rx_state_nxt = IDLE;
          byte_vld     = rx;
          frame_err    = !rx;
        end else begin
          clk_cnt_nxt = clk_cnt + 1'b1;
        end
      end
      default: rx_state_nxt = IDLE;
    endcase
  end

  // Packet counter and inter-byte timeout
  stage_t          stage, stage_nxt;
  logic            cmplt, cmplt_nxt;
  logic [TO_W-1:0] timer, timer_nxt;
  logic            timed_out;

  assign timed_out = (stage != CMD) && (timer == TO_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stage <= CMD;
      cmplt <= 1'b0;
      timer <= '0;
    end else begin
      stage <= stage_nxt;
      cmplt <= cmplt_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    stage_nxt = stage;
    cmplt_nxt = 1'b0;
    timer_nxt = timer;
    if (cmplt) begin
      stage_nxt = CMD;
    end else if (frame_err) begin
      stage_nxt = CMD;
    end else if (byte_vld) begin
      case (stage)
        CMD:     stage_nxt = ADDR;
        ADDR:    stage_nxt = D0;
        D0:      stage_nxt = D1;
        D1:      stage_nxt = D2;
        D2:      stage_nxt = D3;
        D3:      cmplt_nxt = 1'b1;
        default: stage_nxt = CMD;
      endcase
    end else if (timed_out) begin
      stage_nxt = CMD;
    end
    // Timer restarts at each stop sample and only runs while a partial packet waits for a start bit
    if (stage == CMD || rx_state == DATA || rx_state == STOP) begin
      timer_nxt = '0;
    end else if (timer != TO_LAST) begin
      timer_nxt = timer + 1'b1;
    end
  end

  // Shadow registers and output latch
  logic [7:0]  sh_cmd, sh_addr;
  logic [31:0] sh_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_cmd    <= '0;
      sh_addr   <= '0;
      sh_data   <= '0;
      o_command <= '0;
      o_address <= '0;
      o_data    <= '0;
      o_done    <= 1'b0;
    end else begin
      o_done <= cmplt;
      if (cmplt) begin
        o_command <= sh_cmd;
        o_address <= sh_addr;
        o_data    <= sh_data;
      end
      if (byte_vld) begin
        case (stage)
          CMD:     sh_cmd         <= shift;
          ADDR:    sh_addr        <= shift;
          D0:      sh_data[31:24] <= shift;
          D1:      sh_data[23:16] <= shift;
          D2:      sh_data[15:8]  <= shift;
          D3:      sh_data[7:0]   <= shift;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_command_decoder.sv
// Scoreboard bench for uart_command_decoder: stimulus queues expected packets,
// a monitor pops and compares on every o_done pulse.
`timescale 1ns/1ps
module tb_uart_command_decoder;

  localparam int CPB = 16;
  localparam int TOB = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        uart_in;
  logic [7:0]  o_command;
  logic [7:0]  o_address;
  logic [31:0] o_data;
  logic        o_done;

  uart_command_decoder #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .uart_in  (uart_in),
    .o_command(o_command),
    .o_address(o_address),
    .o_data   (o_data),
    .o_done   (o_done)
  );

  always #10 clock = ~clock;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
  } pkt_t;

  pkt_t exp_q[$];
  int   done_times[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor
  initial begin
    pkt_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clock);
      if (o_done === 1'b1) begin
        done_times.push_back(cyc);
        check("done_single_cycle", {31'b0, prev_done}, 32'h0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got cmd=%h addr=%h data=%h expected no packet",
                   o_command, o_address, o_data);
        end else begin
          e = exp_q.pop_front();
          check("command", {24'b0, o_command}, {24'b0, e.cmd});
          check("address", {24'b0, o_address}, {24'b0, e.addr});
          check("data", o_data, e.data);
        end
      end
      prev_done = o_done;
    end
  end

  task automatic bit_time(input logic v);
    uart_in = v;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bit_time(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
  endtask

  task automatic send_pkt(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d);
    pkt_t p;
    p.cmd  = c;
    p.addr = a;
    p.data = d;
    exp_q.push_back(p);
    send_byte(c, 1'b1);
    send_byte(a, 1'b1);
    send_byte(d[31:24], 1'b1);
    send_byte(d[23:16], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
  endtask

  task automatic check_outputs(input string name, input logic [7:0] c, input logic [7:0] a,
                               input logic [31:0] d);
    check({name, "_command"}, {24'b0, o_command}, {24'b0, c});
    check({name, "_address"}, {24'b0, o_address}, {24'b0, a});
    check({name, "_data"}, o_data, d);
  endtask

  // Stimulus
  initial begin
    int base;
    reset   = 1'b1;
    uart_in = 1'b1;
    repeat (3) @(negedge clock);
    check_outputs("reset", 8'h00, 8'h00, 32'h0);
    check("reset_done", {31'b0, o_done}, 32'h0);
    reset = 1'b0;
    idle(2);

    // Basic packet
    send_pkt(8'h00, 8'h01, 32'hAF32CD85);
    idle(2);

    // Short low glitch on the idle line must not start a byte
    uart_in = 1'b0;
    repeat (CPB / 5) @(negedge clock);
    uart_in = 1'b1;
    idle(2);
    send_pkt(8'h00, 8'h01, 32'hAF32CD85);
    idle(2);

    // Framing error aborts the partial packet
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b0);
    idle(2);
    check_outputs("hold_after_frame_err", 8'h00, 8'h01, 32'hAF32CD85);
    send_pkt(8'h05, 8'h07, 32'h12345678);
    idle(2);

    // Reset in the middle of a packet
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h03, 1'b1);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    check_outputs("in_reset", 8'h00, 8'h00, 32'h0);
    check("in_reset_done", {31'b0, o_done}, 32'h0);
    reset = 1'b0;
    idle(2);
    send_pkt(8'hA5, 8'h5A, 32'hDEADBEEF);
    idle(2);

    // Inter-byte timeout discards a partial packet
    send_byte(8'h99, 1'b1);
    send_byte(8'h98, 1'b1);
    idle(20);
    check_outputs("hold_after_timeout", 8'hA5, 8'h5A, 32'hDEADBEEF);
    send_pkt(8'h00, 8'h01, 32'hAF32CD85);
    idle(2);

    // Line stuck low yields no valid packet; trailing partial byte is flushed by timeout
    uart_in = 1'b0;
    repeat (30 * CPB) @(negedge clock);
    idle(30);
    check_outputs("hold_after_stuck_low", 8'h00, 8'h01, 32'hAF32CD85);

    // Two packets back-to-back with no idle gap
    base = done_times.size();
    send_pkt(8'h3C, 8'hC3, 32'h01020304);
    send_pkt(8'hFF, 8'h00, 32'h80000001);
    idle(2);
    check("b2b_done_count", done_times.size() - base, 32'd2);
    if (done_times.size() >= base + 2)
      check("b2b_spacing", done_times[base+1] - done_times[base], 60 * CPB);
    else
      check("b2b_spacing", 32'h0, 60 * CPB);

    idle(2);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    check("total_done", done_times.size(), 32'd7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_command_decoder.md
UART_COMMAND_DECODER -- requirements
Module: uart_command_decoder

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, gives clock cycles per UART bit (115200 baud at 50 MHz); legal range 8..65535.
REQ-002 Parameter TIMEOUT_BITS, default 16, gives the inter-byte idle limit in bit times.
REQ-003 There is one clock and reset is asynchronous and active-high.
REQ-004 clock  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 uart_in  input  1  asynchronous serial line; idle high; 8N1 framing, LSB first.
REQ-007 o_command  output  8  command byte of the last complete packet.
REQ-008 o_address  output  8  address byte of the last complete packet.
REQ-009 o_data  output  32  data word of the last complete packet.
REQ-010 o_done  output  1  single-cycle pulse when a complete packet is latched.

Function
REQ-011 uart_in SHALL pass through a 2-flop synchronizer before use; that latency is not counted below.
REQ-012 The byte receiver SHALL use states IDLE, START, DATA, STOP.
- IDLE: wait for low on the synchronized line.
- START: wait CLKS_PER_BIT/2 cycles (integer divide); line still low -> DATA, else -> IDLE (false start, nothing recorded).
- DATA: sample 8 bits, each CLKS_PER_BIT cycles after the previous sample, bit 0 first.
- STOP: sample CLKS_PER_BIT cycles after bit 7; high -> byte valid, low -> framing error; then return to IDLE.
REQ-013 A packet SHALL be 6 bytes in order: command, address, data[31:24], data[23:16], data[15:8], data[7:0].
REQ-014 A packet counter SHALL track stages CMD, ADDR, D0, D1, D2, D3; each valid byte is stored in a shadow register and advances the stage.
REQ-015 When a valid byte completes stage D3, the counter SHALL return to CMD on the next rising edge. On that same edge:
- all three outputs load from the shadow registers;
- o_done goes high for exactly one cycle.
REQ-016 Outputs SHALL update only on packet completion and otherwise hold their values; partial packets never change them.
REQ-017 A framing error SHALL discard the byte and return the packet counter to CMD. Outputs and o_done are unaffected.
REQ-018 If the counter is not in CMD and no start bit is detected for TIMEOUT_BITS*CLKS_PER_BIT cycles after the last stop sample, the counter SHALL return to CMD.
REQ-019 Back-to-back frames with no idle time between stop and next start bit SHALL be received without loss. After the stop sample the receiver SHALL be able to detect a falling edge on the next cycle.
REQ-020 Consecutive packets with no gap SHALL each produce one o_done pulse.
REQ-021 A line held permanently low SHALL NOT produce valid bytes, because every stop sample fails.
REQ-022 All counters SHALL be sized for CLKS_PER_BIT and TIMEOUT_BITS*CLKS_PER_BIT without wrap-around.

Reset
REQ-023 On reset assertion the following SHALL clear asynchronously:
- o_command, o_address, o_data to 0; o_done to 0;
- shadow registers to 0;
- byte receiver to IDLE; packet counter to CMD; all timers to 0;
- synchronizer flops to 1.
REQ-024 Reset asserted mid-byte or mid-packet SHALL abandon the partial packet. After release, the next start bit is treated as a command byte.

Verification
REQ-025 50 MHz clock, default parameters; send bytes 0x00, 0x01, 0xAF, 0x32, 0xCD, 0x85 -> o_command=0x00, o_address=0x01, o_data=0xAF32CD85, o_done high exactly one cycle.
REQ-026 A 0.2-bit-time low glitch on idle line, then the REQ-025 packet -> no byte recorded from the glitch, REQ-025 outputs produced.
REQ-027 Send 0x11, 0x22, then a byte with stop bit forced low, then packet 0x05, 0x07, 0x12, 0x34, 0x56, 0x78 -> no o_done for the aborted packet; then o_command=0x05, o_address=0x07, o_data=0x12345678, one o_done pulse.
REQ-028 Assert reset after 3 bytes of a packet, release, send 0xA5, 0x5A, 0xDE, 0xAD, 0xBE, 0xEF -> all outputs 0 during reset; then o_command=0xA5, o_address=0x5A, o_data=0xDEADBEEF.
REQ-029 Send 2 bytes, idle 20 bit times, then the REQ-025 packet -> timeout discards the 2 bytes, REQ-025 outputs produced.
REQ-030 Send two packets back-to-back with zero idle gap -> two o_done pulses 60 bit times apart, each with correct values.
